// File: rtl/axis_tx_frame_buffer.sv
// Store-and-forward AXI-Stream frame buffer for the Ethernet TX path.
// A frame is released to the MAC side only after its tlast beat is stored.
// Frames too large for the buffer are discarded without stalling the source.
module axis_tx_frame_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned MAX_FRAMES = 16,
  localparam int unsigned ADDR_W    = $clog2(DEPTH),
  localparam int unsigned FC_W      = $clog2(MAX_FRAMES) + 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [FC_W-1:0]       frame_count,
  output logic                  drop_pulse
);

  localparam logic [ADDR_W:0] DepthPtr = (ADDR_W + 1)'(DEPTH);
  localparam logic [FC_W-1:0] MaxFc    = FC_W'(MAX_FRAMES);

  typedef enum logic [1:0] {WrIdle, WrFrame, WrDrop} wr_state_e;
  typedef enum logic [1:0] {RdIdle, RdLoad, RdBurst} rd_state_e;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [ADDR_W:0]       wr_ptr_q, commit_ptr_q, rd_ptr_q, used;
  logic [FC_W-1:0]       frame_count_q, frame_count_d;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_last_q, m_valid_q, drop_q;
  logic                  full, drop_now, wr_accept, m_accept;
  logic                  mem_we, commit, rewind, drop, load, finish;

  assign used      = wr_ptr_q - rd_ptr_q;
  assign full      = (used == DepthPtr);
  // Open frame already occupies the whole buffer: it can never be committed.
  assign drop_now  = (wr_state_q == WrFrame) && full && (commit_ptr_q == rd_ptr_q);
  assign wr_accept = s_axis_tvalid && s_axis_tready;
  assign m_accept  = m_valid_q && m_axis_tready;

  // Write-side ready; held low during reset so every output reads 0.
  always_comb begin
    s_axis_tready = 1'b0;
    if (!areset) begin
      if (wr_state_q == WrDrop || drop_now) begin
        s_axis_tready = 1'b1;
      end else begin
        s_axis_tready = !full && (frame_count_q < MaxFc);
      end
    end
  end

  // Write FSM next state and datapath strobes.
  always_comb begin
    wr_state_d = wr_state_q;
    mem_we     = 1'b0;
    commit     = 1'b0;
    rewind     = 1'b0;
    drop       = 1'b0;
    unique case (wr_state_q)
      WrIdle: begin
        if (wr_accept) begin
          mem_we = 1'b1;
          if (s_axis_tlast) commit = 1'b1;
          else              wr_state_d = WrFrame;
        end
      end
      WrFrame: begin
        if (drop_now) begin
          // A beat accepted in this cycle is already part of the discarded frame.
          rewind = 1'b1;
          if (wr_accept && s_axis_tlast) begin
            drop       = 1'b1;
            wr_state_d = WrIdle;
          end else begin
            wr_state_d = WrDrop;
          end
        end else if (wr_accept) begin
          mem_we = 1'b1;
          if (s_axis_tlast) begin
            commit     = 1'b1;
            wr_state_d = WrIdle;
          end
        end
      end
      WrDrop: begin
        if (wr_accept && s_axis_tlast) begin
          drop       = 1'b1;
          wr_state_d = WrIdle;
        end
      end
      default: wr_state_d = WrIdle;
    endcase
  end

  // Read FSM next state and datapath strobes.
  always_comb begin
    rd_state_d = rd_state_q;
    load       = 1'b0;
    finish     = 1'b0;
    unique case (rd_state_q)
      RdIdle: begin
        if (frame_count_q != '0) rd_state_d = RdLoad;
      end
      RdLoad: begin
        load       = 1'b1;
        rd_state_d = RdBurst;
      end
      RdBurst: begin
        if (m_accept) begin
          if (m_last_q) begin
            finish     = 1'b1;
            rd_state_d = RdIdle;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: rd_state_d = RdIdle;
    endcase
  end

  // Committed-frame count; a commit and a completed send in one cycle cancel.
  always_comb begin
    frame_count_d = frame_count_q;
    if (commit && !finish)      frame_count_d = frame_count_q + FC_W'(1);
    else if (!commit && finish) frame_count_d = frame_count_q - FC_W'(1);
  end

  // Both FSM state registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_state_q <= WrIdle;
      rd_state_q <= RdIdle;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
    end
  end

  // Buffer storage; contents need no reset.
  always_ff @(posedge aclk) begin
    if (mem_we) mem[wr_ptr_q[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tdata};
  end

  // Pointers, frame count, output register and drop pulse.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q      <= '0;
      commit_ptr_q  <= '0;
      rd_ptr_q      <= '0;
      frame_count_q <= '0;
      m_data_q      <= '0;
      m_last_q      <= 1'b0;
      m_valid_q     <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      if (rewind)      wr_ptr_q <= commit_ptr_q;
      else if (mem_we) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (commit) commit_ptr_q <= wr_ptr_q + 1'b1;
      if (load) begin
        {m_last_q, m_data_q} <= mem[rd_ptr_q[ADDR_W-1:0]];
        rd_ptr_q             <= rd_ptr_q + 1'b1;
        m_valid_q            <= 1'b1;
      end else if (finish) begin
        m_valid_q <= 1'b0;
      end
      frame_count_q <= frame_count_d;
      drop_q        <= drop;
    end
  end

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tvalid = m_valid_q;
  assign frame_count   = frame_count_q;
  assign drop_pulse    = drop_q;

endmodule

// File: tb/tb_axis_tx_frame_buffer.sv
// Directed self-checking bench for axis_tx_frame_buffer.
module tb_axis_tx_frame_buffer;

  logic        clk = 1'b0;
  logic        areset = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b0;
  logic [4:0]  frame_count;
  logic        drop_pulse;

  int tests = 0;
  int fails = 0;
  int stall_cnt = 0;
  int cyc = 0;
  int drops = 0;
  int last_s_cyc = 0;
  logic prev_v = 1'b0;
  logic [32:0] got[$];
  int rise_q[$];
  int mlast_q[$];

  axis_tx_frame_buffer #(
    .DATA_WIDTH(32),
    .DEPTH     (256),
    .MAX_FRAMES(16)
  ) dut (
    .aclk         (clk),
    .areset       (areset),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .frame_count  (frame_count),
    .drop_pulse   (drop_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record m-side transfers, tvalid rising edges and drop pulses between edges.
  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      got.push_back({m_axis_tlast, m_axis_tdata});
      if (m_axis_tlast) mlast_q.push_back(cyc);
    end
    if (m_axis_tvalid && !prev_v) rise_q.push_back(cyc);
    prev_v <= m_axis_tvalid;
    if (s_axis_tvalid && s_axis_tready && s_axis_tlast) last_s_cyc <= cyc;
    if (drop_pulse) drops <= drops + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_beat(input logic [31:0] d, input logic l);
    int n = 0;
    bit done = 1'b0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (s_axis_tready === 1'b1) begin
        done = 1'b1;
      end else begin
        stall_cnt++;
        n++;
        if (n >= 3000) begin
          tests++;
          fails++;
          $display("FAIL wr_beat_timeout: beat %0h waited %0d cycles, required acceptance", d, n);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget, input string name);
    int k = 0;
    while (got.size() < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    tests++;
    if (got.size() < n) begin
      fails++;
      $display("FAIL %s_timeout: got %0d beats, required %0d", name, got.size(), n);
    end
  endtask

  function automatic logic [31:0] pat(input int f, input int j);
    return 32'hC000_0000 | (32'(f) << 16) | 32'(j);
  endfunction

  task automatic test_reset();
    #1 areset = 1'b1;
    #1;
    tests++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, drop_pulse} !== 4'b0 ||
        m_axis_tdata !== 32'h0 || frame_count !== 5'd0) begin
      fails++;
      $display("FAIL reset_outputs: tready %b tvalid %b tlast %b drop %b data %0h fc %0d, required all 0",
               s_axis_tready, m_axis_tvalid, m_axis_tlast, drop_pulse, m_axis_tdata, frame_count);
    end
    repeat (3) @(posedge clk);
    #2 areset = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0 || frame_count !== 5'd0) begin
      fails++;
      $display("FAIL reset_release: tready %b tvalid %b fc %0d, required 1 0 0",
               s_axis_tready, m_axis_tvalid, frame_count);
    end
  endtask

  task automatic test_basic();
    int base = got.size();
    int rb = rise_q.size();
    int lat = -1;
    m_axis_tready = 1'b1;
    tests++;
    if (frame_count !== 5'd0) begin
      fails++;
      $display("FAIL basic_fc_start: got %0d, required 0", frame_count);
    end
    for (int i = 0; i < 4; i++) wr_beat(32'hA0 + 32'(i), (i == 3));
    tests++;
    if (frame_count !== 5'd1) begin
      fails++;
      $display("FAIL basic_fc_commit: got %0d, required 1", frame_count);
    end
    wait_got(base + 4, 100, "basic");
    wait_cycles(3);
    tests++;
    if (frame_count !== 5'd0) begin
      fails++;
      $display("FAIL basic_fc_end: got %0d, required 0", frame_count);
    end
    for (int i = 0; i < 4; i++) begin
      logic [32:0] exp = {(i == 3), 32'hA0 + 32'(i)};
      tests++;
      if (got.size() <= base + i || got[base + i] !== exp) begin
        fails++;
        $display("FAIL basic_beat%0d: got %0h, required %0h", i,
                 (got.size() > base + i) ? got[base + i] : 33'h0, exp);
      end
    end
    if (rise_q.size() > rb) lat = rise_q[rb] - last_s_cyc;
    tests++;
    if (lat != 3) begin
      fails++;
      $display("FAIL basic_latency: got %0d cycles, required 3", lat);
    end
  endtask

  task automatic test_back_to_back();
    int base = got.size();
    int rb = rise_q.size();
    int mb = mlast_q.size();
    int gap;
    m_axis_tready = 1'b1;
    for (int f = 0; f < 3; f++)
      for (int j = 0; j < 2; j++) wr_beat(32'h200 + 32'(f * 2 + j), (j == 1));
    // Third commit coincides with the first frame's last m-side transfer.
    tests++;
    if (frame_count !== 5'd2) begin
      fails++;
      $display("FAIL b2b_fc_coincide: got %0d, required 2", frame_count);
    end
    wait_got(base + 6, 100, "b2b");
    wait_cycles(2);
    for (int i = 0; i < 6; i++) begin
      logic [32:0] exp = {(i % 2 == 1), 32'h200 + 32'(i)};
      tests++;
      if (got.size() <= base + i || got[base + i] !== exp) begin
        fails++;
        $display("FAIL b2b_beat%0d: got %0h, required %0h", i,
                 (got.size() > base + i) ? got[base + i] : 33'h0, exp);
      end
    end
    for (int k = 0; k < 2; k++) begin
      gap = -1;
      if (rise_q.size() > rb + k + 1 && mlast_q.size() > mb + k)
        gap = rise_q[rb + k + 1] - mlast_q[mb + k];
      tests++;
      if (gap != 3) begin
        fails++;
        $display("FAIL b2b_gap%0d: got %0d, required 3", k, gap);
      end
    end
  endtask

  task automatic test_frame_limit();
    int base = got.size();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 16; i++) wr_beat(32'h300 + 32'(i), 1'b1);
    tests++;
    if (frame_count !== 5'd16 || s_axis_tready !== 1'b0) begin
      fails++;
      $display("FAIL limit_block: fc %0d tready %b, required 16 0", frame_count, s_axis_tready);
    end
    s_axis_tdata  = 32'h310;
    s_axis_tlast  = 1'b1;
    s_axis_tvalid = 1'b1;
    wait_cycles(4);
    tests++;
    if (frame_count !== 5'd16) begin
      fails++;
      $display("FAIL limit_hold: fc %0d, required 16", frame_count);
    end
    m_axis_tready = 1'b1;
    wr_beat(32'h310, 1'b1);
    tests++;
    if (got.size() - base < 1) begin
      fails++;
      $display("FAIL limit_order: m transfers before 17th accept %0d, required >=1",
               got.size() - base);
    end
    wait_got(base + 17, 300, "limit");
    for (int i = 0; i < 17; i++) begin
      logic [32:0] exp = {1'b1, 32'h300 + 32'(i)};
      tests++;
      if (got.size() <= base + i || got[base + i] !== exp) begin
        fails++;
        $display("FAIL limit_beat%0d: got %0h, required %0h", i,
                 (got.size() > base + i) ? got[base + i] : 33'h0, exp);
        break;
      end
    end
    wait_cycles(5);
  endtask

  task automatic test_oversize();
    int base = got.size();
    int s0 = stall_cnt;
    int d0 = drops;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 266; i++) wr_beat(32'hD000_0000 + 32'(i), (i == 265));
    wait_cycles(10);
    tests++;
    if (stall_cnt - s0 != 0) begin
      fails++;
      $display("FAIL oversize_tready: stalled %0d cycles, required 0", stall_cnt - s0);
    end
    tests++;
    if (drops - d0 != 1) begin
      fails++;
      $display("FAIL oversize_drop: pulses %0d, required 1", drops - d0);
    end
    tests++;
    if (got.size() != base || frame_count !== 5'd0) begin
      fails++;
      $display("FAIL oversize_silent: m beats %0d fc %0d, required 0 0",
               got.size() - base, frame_count);
    end
    wr_beat(32'hB0, 1'b0);
    wr_beat(32'hB1, 1'b1);
    wait_got(base + 2, 100, "oversize_next");
    tests++;
    if (got.size() < base + 2 || got[base] !== {1'b0, 32'hB0} || got[base + 1] !== {1'b1, 32'hB1})
    begin
      fails++;
      $display("FAIL oversize_next: got %0h %0h, required 0b0 1000000b1",
               (got.size() > base) ? got[base] : 33'h0,
               (got.size() > base + 1) ? got[base + 1] : 33'h0);
    end
  endtask

  task automatic test_stall();
    int base = got.size();
    int lens[3] = '{1, 7, 256};
    fork
      begin
        for (int f = 0; f < 3; f++)
          for (int j = 0; j < lens[f]; j++) wr_beat(pat(f, j), (j == lens[f] - 1));
      end
      begin
        logic        prev_stall = 1'b0;
        logic [32:0] prev_word = '0;
        int          k = 0;
        while (got.size() < base + 264 && k < 6000) begin
          @(posedge clk);
          #1 m_axis_tready = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (prev_stall) begin
            tests++;
            if (m_axis_tvalid !== 1'b1 || {m_axis_tlast, m_axis_tdata} !== prev_word) begin
              fails++;
              $display("FAIL stall_hold: valid %b word %0h, required 1 %0h",
                       m_axis_tvalid, {m_axis_tlast, m_axis_tdata}, prev_word);
            end
          end
          prev_stall = m_axis_tvalid && !m_axis_tready;
          prev_word  = {m_axis_tlast, m_axis_tdata};
          k++;
        end
      end
    join
    m_axis_tready = 1'b1;
    wait_got(base + 264, 50, "stall");
    begin
      int idx = base;
      for (int f = 0; f < 3; f++) begin
        for (int j = 0; j < lens[f]; j++) begin
          logic [32:0] exp = {(j == lens[f] - 1), pat(f, j)};
          tests++;
          if (got.size() <= idx || got[idx] !== exp) begin
            fails++;
            $display("FAIL stall_f%0d_b%0d: got %0h, required %0h", f, j,
                     (got.size() > idx) ? got[idx] : 33'h0, exp);
            break;
          end
          idx++;
        end
      end
    end
    wait_cycles(5);
  endtask

  task automatic test_async_reset();
    int base;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) wr_beat(32'hE0 + 32'(i), (i == 3));
    for (int i = 0; i < 3; i++) wr_beat(32'hF0 + 32'(i), 1'b0);
    wait_cycles(2);
    tests++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hE0) begin
      fails++;
      $display("FAIL areset_pre: valid %b data %0h, required 1 e0", m_axis_tvalid, m_axis_tdata);
    end
    #2 areset = 1'b1;
    #1;
    tests++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, drop_pulse} !== 4'b0 ||
        m_axis_tdata !== 32'h0 || frame_count !== 5'd0) begin
      fails++;
      $display("FAIL areset_now: tready %b tvalid %b tlast %b drop %b data %0h fc %0d, required all 0",
               s_axis_tready, m_axis_tvalid, m_axis_tlast, drop_pulse, m_axis_tdata, frame_count);
    end
    repeat (2) @(posedge clk);
    #2 areset = 1'b0;
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    base = got.size();
    for (int i = 0; i < 3; i++) wr_beat(32'h70 + 32'(i), (i == 2));
    wait_got(base + 3, 100, "areset_fresh");
    wait_cycles(10);
    tests++;
    if (got.size() != base + 3) begin
      fails++;
      $display("FAIL areset_count: got %0d beats, required 3", got.size() - base);
    end
    for (int i = 0; i < 3; i++) begin
      logic [32:0] exp = {(i == 2), 32'h70 + 32'(i)};
      tests++;
      if (got.size() <= base + i || got[base + i] !== exp) begin
        fails++;
        $display("FAIL areset_beat%0d: got %0h, required %0h", i,
                 (got.size() > base + i) ? got[base + i] : 33'h0, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_frame_limit();
    test_oversize();
    test_stall();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
